wb_spi_ctrl: RTL and testbench

//   Wishbone B4 peripheral that drives an SPI bus as controller (mode 0, MSB first, 8-bit frames).
//   It is the counterpart to our SPI-peripheral/Wishbone-controller bridge: the FPGA-side SoC writes a

---
 rtl/wb_spi_pkg.sv | 63 ++++++
 rtl/wb_spi_shifter.sv | 127 ++++++++++++
 rtl/wb_spi_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_wb_spi_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_spi_pkg
//  Description : Shared definitions for the Wishbone SPI controller:
//                register addresses, STATUS/CTRL bit positions, shifter FSM
//                state encoding and the Wishbone/SPI bundle types used on the
//                top-level ports.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_spi_pkg;

  // Register map (Wishbone word address)
  localparam logic [1:0] WB_SPI_DATA   = 2'd0;
  localparam logic [1:0] WB_SPI_STATUS = 2'd1;
  localparam logic [1:0] WB_SPI_CTRL   = 2'd2;

  // STATUS bit positions
  localparam int STATUS_BUSY     = 0;
  localparam int STATUS_RX_VALID = 1;
  localparam int STATUS_OVERRUN  = 2;

  // CTRL bit positions
  localparam int CTRL_CS_LEVEL  = 0;
  localparam int CTRL_CS_MANUAL = 1;
  localparam int CTRL_IE        = 2;

  // Shifter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } spi_state_e;

  // Wishbone controller -> peripheral signals
  typedef struct packed {
    logic       cyc;
    logic       stb;
    logic       we;
    logic [1:0] adr;
    logic [7:0] dat;
  } iWishbone_Ctrl;

  // Wishbone peripheral -> controller signals
  typedef struct packed {
    logic       ack;
    logic [7:0] dat;
  } iWishbone_Peri;

  // SPI controller-driven lines
  typedef struct packed {
    logic sck;
    logic csn;
    logic sdo;
  } iSpi_Ctrl;

  // SPI peripheral-driven lines
  typedef struct packed {
    logic sdi;
  } iSpi_Peri;

endpackage
`default_nettype wire

// File: rtl/wb_spi_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_spi_shifter
//  Description : SPI mode-0 byte engine: SCK divider, IDLE/LOW/HIGH/DONE FSM
//                and 8-bit MSB-first shift registers.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk      in   system clock
//    rst      in   asynchronous active-high reset
//    start    in   one-cycle request, honoured only in IDLE
//    tx_byte  in   byte to transmit, captured on start
//    sdi      in   serial data from the peripheral
//    busy     out  high from LOW entry through DONE (drives auto chip select)
//    done     out  one-cycle pulse while in DONE; rx_byte is complete
//    rx_byte  out  received byte
//    sck      out  serial clock (high only in HIGH)
//    sdo      out  serial data to the peripheral (0 outside LOW/HIGH)
//
//  Parameters
//    CLK_DIV  clk cycles per SCK half-period (>=1)
// ============================================================================
module wb_spi_shifter
  import wb_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       sdi,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       sck,
  output logic       sdo
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  // Counter runs CLK_DIV-1 down to 0, so each phase lasts CLK_DIV cycles.
  localparam logic [DIV_W-1:0] c_div_load = DIV_W'(CLK_DIV - 1);

  spi_state_e       r_state;
  spi_state_e       w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_tx_shift;
  logic [7:0]       r_rx_shift;
  logic             w_div_end;

  assign w_div_end = (r_div == '0);
  assign rx_byte   = r_rx_shift;

  // Next-state and output decode
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    sck         = 1'b0;
    sdo         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = LOW;
      end
      LOW: begin
        busy = 1'b1;
        sdo  = r_tx_shift[7];
        if (w_div_end) w_state_nxt = HIGH;
      end
      HIGH: begin
        busy = 1'b1;
        sck  = 1'b1;
        sdo  = r_tx_shift[7];
        if (w_div_end) w_state_nxt = (r_bit_cnt == 3'd0) ? DONE : LOW;
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_div      <= '0;
      r_bit_cnt  <= 3'd0;
      r_tx_shift <= 8'h00;
      r_rx_shift <= 8'h00;
    end else begin
      r_state <= w_state_nxt;

      // Divider reloads on every state change and holds at zero otherwise.
      if (w_state_nxt != r_state) begin
        r_div <= c_div_load;
      end else if (!w_div_end) begin
        r_div <= r_div - 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_tx_shift <= tx_byte;
            r_bit_cnt  <= 3'd7;
          end
        end
        LOW: begin
          // LOW->HIGH transition is the rising SCK edge: sample sdi here.
          if (w_div_end) r_rx_shift <= {r_rx_shift[6:0], sdi};
        end
        HIGH: begin
          // Falling edge into the next LOW presents the next bit.
          if (w_div_end && (r_bit_cnt != 3'd0)) begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            r_bit_cnt  <= r_bit_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_spi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wb_spi_ctrl
//  Description : Wishbone B4 peripheral driving an SPI bus as controller
//                (mode 0, MSB first, 8-bit frames). Holds the register file,
//                Wishbone decode, chip-select mux, status flags and optional
//                interrupt; the bit engine lives in wb_spi_shifter.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk    in   system clock
//    rst    in   asynchronous active-high reset
//    wb_c   in   Wishbone cyc/stb/we/adr[1:0]/dat[7:0]
//    wb_p   out  Wishbone ack/dat[7:0]
//    spi_c  out  sck/csn/sdo
//    spi_p  in   sdi
//    irq    out  (only with WB_SPI_CTRL_IRQ_EN) rx_valid & CTRL.ie, registered
//
//  Parameters
//    CLK_DIV  clk cycles per SCK half-period (>=1)
//
//  Build option
//    WB_SPI_CTRL_IRQ_EN  adds the irq port and makes CTRL.ie writable
//
//  Registers
//    0 DATA    W: tx byte / start   R: rx byte, clears rx_valid
//    1 STATUS  R: {overrun, rx_valid, busy}   W: bit2=1 clears overrun
//    2 CTRL    RW: {ie, cs_manual, cs_level}
//    3 reserved, reads 0
// ============================================================================
module wb_spi_ctrl
  import wb_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  iWishbone_Ctrl wb_c,
  output iWishbone_Peri wb_p,
  output iSpi_Ctrl      spi_c,
  input  iSpi_Peri      spi_p
`ifdef WB_SPI_CTRL_IRQ_EN
  ,
  output logic          irq
`endif
);

`ifdef WB_SPI_CTRL_IRQ_EN
  localparam logic [2:0] c_ctrl_mask = 3'b111;
`else
  localparam logic [2:0] c_ctrl_mask = 3'b011;
`endif

  logic       r_ack;
  logic [7:0] r_rdat;
  logic [2:0] r_ctrl;
  logic       r_busy;
  logic       r_rx_valid;
  logic       r_overrun;
  logic [7:0] r_rx_byte;
  logic [7:0] r_tx_byte;
  logic       r_start;

  logic       w_req;
  logic       w_wr;
  logic       w_rd;
  logic       w_data_wr;
  logic       w_data_rd;
  logic       w_stat_wr;
  logic       w_ctrl_wr;
  logic       w_start_ok;
  logic       w_busy_nxt;
  logic       w_rx_valid_nxt;
  logic       w_overrun_nxt;
  logic [2:0] w_ctrl_nxt;
  logic [7:0] w_rdat_mux;

  logic       w_sh_busy;
  logic       w_sh_done;
  logic [7:0] w_sh_rx;
  logic       w_sck;
  logic       w_sdo;

  // Wishbone decode: a request is accepted once, in the cycle before ack.
  assign w_req      = wb_c.cyc & wb_c.stb & ~r_ack;
  assign w_wr       = w_req & wb_c.we;
  assign w_rd       = w_req & ~wb_c.we;
  assign w_data_wr  = w_wr & (wb_c.adr == WB_SPI_DATA);
  assign w_data_rd  = w_rd & (wb_c.adr == WB_SPI_DATA);
  assign w_stat_wr  = w_wr & (wb_c.adr == WB_SPI_STATUS);
  assign w_ctrl_wr  = w_wr & (wb_c.adr == WB_SPI_CTRL);
  assign w_start_ok = w_data_wr & ~r_busy;

  // Flag and register next-state. Sets are applied after clears so that a
  // set in the same cycle wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_sh_done)  w_busy_nxt = 1'b0;
    if (w_start_ok) w_busy_nxt = 1'b1;

    w_rx_valid_nxt = r_rx_valid;
    if (w_data_rd) w_rx_valid_nxt = 1'b0;
    if (w_sh_done) w_rx_valid_nxt = 1'b1;

    w_overrun_nxt = r_overrun;
    if (w_stat_wr && wb_c.dat[STATUS_OVERRUN]) w_overrun_nxt = 1'b0;
    if (w_data_wr && r_busy)                   w_overrun_nxt = 1'b1;
    if (w_sh_done && r_rx_valid)               w_overrun_nxt = 1'b1;

    w_ctrl_nxt = r_ctrl;
    if (w_ctrl_wr) w_ctrl_nxt = wb_c.dat[2:0] & c_ctrl_mask;
  end

  // Read mux
  always_comb begin
    w_rdat_mux = 8'h00;
    case (wb_c.adr)
      WB_SPI_DATA:   w_rdat_mux = r_rx_byte;
      WB_SPI_STATUS: w_rdat_mux = {5'b0, r_overrun, r_rx_valid, r_busy};
      WB_SPI_CTRL:   w_rdat_mux = {5'b0, r_ctrl};
      default:       w_rdat_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack      <= 1'b0;
      r_rdat     <= 8'h00;
      r_ctrl     <= 3'b000;
      r_busy     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_rx_byte  <= 8'h00;
      r_tx_byte  <= 8'h00;
      r_start    <= 1'b0;
    end else begin
      r_ack      <= w_req;
      // Read data is captured from pre-update register values, so a DATA
      // read coinciding with DONE returns the previous byte.
      r_rdat     <= w_rd ? w_rdat_mux : 8'h00;
      r_ctrl     <= w_ctrl_nxt;
      r_busy     <= w_busy_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_overrun  <= w_overrun_nxt;
      r_start    <= w_start_ok;
      if (w_start_ok) r_tx_byte <= wb_c.dat;
      if (w_sh_done)  r_rx_byte <= w_sh_rx;
    end
  end

`ifdef WB_SPI_CTRL_IRQ_EN
  logic r_irq;

  // Tracks the flag values being registered this edge so irq moves in the
  // same cycle as rx_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_rx_valid_nxt & w_ctrl_nxt[CTRL_IE];
    end
  end

  assign irq = r_irq;
`endif

  wb_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .start   (r_start),
    .tx_byte (r_tx_byte),
    .sdi     (spi_p.sdi),
    .busy    (w_sh_busy),
    .done    (w_sh_done),
    .rx_byte (w_sh_rx),
    .sck     (w_sck),
    .sdo     (w_sdo)
  );

  always_comb begin
    wb_p     = '0;
    wb_p.ack = r_ack;
    wb_p.dat = r_rdat;
  end

  // Manual chip select overrides the automatic frame-wide assertion.
  always_comb begin
    spi_c     = '0;
    spi_c.sck = w_sck;
    spi_c.sdo = w_sdo;
    spi_c.csn = r_ctrl[CTRL_CS_MANUAL] ? r_ctrl[CTRL_CS_LEVEL] : ~w_sh_busy;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_spi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_spi_ctrl
//  Description : Self-checking bench for wb_spi_ctrl. Two instances
//                (CLK_DIV=4 and CLK_DIV=1) share the Wishbone stimulus; a
//                mode-0 SPI device model answers on the selected instance,
//                echoing the previously received byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_spi_ctrl;
  import wb_spi_pkg::*;

  logic          clk;
  logic          rst;
  logic          sel;
  iWishbone_Ctrl wb_c;
  iWishbone_Peri wb_p0, wb_p1;
  iSpi_Ctrl      spi_c0, spi_c1;
  iSpi_Peri      spi_p;
`ifdef WB_SPI_CTRL_IRQ_EN
  logic          irq0, irq1;
`endif

  int checks   = 0;
  int failures = 0;

  wb_spi_ctrl #(.CLK_DIV(4)) u_dut0 (
    .clk   (clk),
    .rst   (rst),
    .wb_c  (wb_c),
    .wb_p  (wb_p0),
    .spi_c (spi_c0),
    .spi_p (spi_p)
`ifdef WB_SPI_CTRL_IRQ_EN
    ,
    .irq   (irq0)
`endif
  );

  wb_spi_ctrl #(.CLK_DIV(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .wb_c  (wb_c),
    .wb_p  (wb_p1),
    .spi_c (spi_c1),
    .spi_p (spi_p)
`ifdef WB_SPI_CTRL_IRQ_EN
    ,
    .irq   (irq1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selected-instance views
  logic       ack_s, sck_s, csn_s, sdo_s;
  logic [7:0] rdat_s;
  assign ack_s  = sel ? wb_p1.ack : wb_p0.ack;
  assign rdat_s = sel ? wb_p1.dat : wb_p0.dat;
  assign sck_s  = sel ? spi_c1.sck : spi_c0.sck;
  assign csn_s  = sel ? spi_c1.csn : spi_c0.csn;
  assign sdo_s  = sel ? spi_c1.sdo : spi_c0.sdo;

  // SPI device model: sample sdo on rising SCK, shift on falling SCK; after
  // the 8th bit, the received byte becomes the next byte to send.
  logic [7:0] m_seed, m_tx, m_rx, m_last;
  int         m_cnt;
  assign spi_p.sdi = m_tx[7];

  always @(posedge sck_s or negedge sck_s or posedge rst) begin
    if (rst) begin
      m_tx   <= m_seed;
      m_rx   <= 8'h00;
      m_last <= 8'h00;
      m_cnt  <= 0;
    end else if (sck_s) begin
      m_rx  <= {m_rx[6:0], sdo_s};
      m_cnt <= m_cnt + 1;
    end else if (m_cnt == 8) begin
      m_tx   <= m_rx;
      m_last <= m_rx;
      m_cnt  <= 0;
    end else begin
      m_tx <= {m_tx[6:0], 1'b0};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One Wishbone access; call at posedge+1. Returns at (ack edge)+1.
  task automatic wb_acc(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                        output logic [7:0] rdat);
    @(posedge clk); #1;
    wb_c.cyc = 1'b1; wb_c.stb = 1'b1; wb_c.we = we; wb_c.adr = adr; wb_c.dat = dat;
    @(posedge clk); #1;
    check("ack", ack_s, 1'b1);
    rdat = rdat_s;
    wb_c.cyc = 1'b0; wb_c.stb = 1'b0; wb_c.we = 1'b0;
  endtask

  task automatic do_reset(input logic [7:0] seed);
    m_seed = seed;
    @(posedge clk); #3;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Cycle-by-cycle watch of a frame in automatic chip-select mode, counted
  // from the DATA ack edge.
  task automatic measure(output int first, output int second, output int rises, output int done_at);
    logic prev, seen_low;
    first = 0; second = 0; rises = 0; done_at = 0; prev = 1'b0; seen_low = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      if (!csn_s) seen_low = 1'b1;
      if (sck_s && !prev) begin
        rises++;
        if (first == 0) first = c;
        else if (second == 0) second = c;
      end
      prev = sck_s;
      if (seen_low && csn_s) begin
        done_at = c;
        break;
      end
    end
  endtask

  task automatic wait_idle(output logic [7:0] s);
    s = 8'hFF;
    for (int i = 0; i < 100; i++) begin
      wb_acc(1'b0, WB_SPI_STATUS, 8'h00, s);
      if (!s[STATUS_BUSY]) break;
    end
  endtask

  typedef struct {
    logic       we;
    logic [1:0] adr;
    logic [7:0] wdat;
    logic [7:0] exp;
    logic       exp_csn;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r, s;
    int first, second, rises, done_at;

    wb_c = '0; rst = 1'b1; sel = 1'b0; m_seed = 8'h00;

    vecs[0]  = '{1'b0, WB_SPI_STATUS, 8'h00, 8'h00, 1'b1};
    vecs[1]  = '{1'b0, WB_SPI_DATA,   8'h00, 8'h00, 1'b1};
    vecs[2]  = '{1'b0, WB_SPI_CTRL,   8'h00, 8'h00, 1'b1};
    vecs[3]  = '{1'b1, WB_SPI_CTRL,   8'h02, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, WB_SPI_CTRL,   8'h00, 8'h02, 1'b0};
    vecs[5]  = '{1'b1, WB_SPI_CTRL,   8'h03, 8'h00, 1'b1};
    vecs[6]  = '{1'b0, WB_SPI_CTRL,   8'h00, 8'h03, 1'b1};
    vecs[7]  = '{1'b1, WB_SPI_CTRL,   8'hFF, 8'h00, 1'b1};
`ifdef WB_SPI_CTRL_IRQ_EN
    vecs[8]  = '{1'b0, WB_SPI_CTRL,   8'h00, 8'h07, 1'b1};
`else
    vecs[8]  = '{1'b0, WB_SPI_CTRL,   8'h00, 8'h03, 1'b1};
`endif
    vecs[9]  = '{1'b1, 2'd3,          8'hFF, 8'h00, 1'b1};
    vecs[10] = '{1'b0, 2'd3,          8'h00, 8'h00, 1'b1};
    vecs[11] = '{1'b1, WB_SPI_CTRL,   8'h00, 8'h00, 1'b1};
    vecs[12] = '{1'b0, WB_SPI_CTRL,   8'h00, 8'h00, 1'b1};
    vecs[13] = '{1'b1, WB_SPI_STATUS, 8'hFF, 8'h00, 1'b1};
    vecs[14] = '{1'b0, WB_SPI_STATUS, 8'h00, 8'h00, 1'b1};

    do_reset(8'h00);
    check("reset_csn", csn_s, 1'b1);
    check("reset_sck", sck_s, 1'b0);
    check("reset_sdo", sdo_s, 1'b0);
    check("reset_ack", ack_s, 1'b0);

    // Register access table
    for (int i = 0; i < 15; i++) begin
      wb_acc(vecs[i].we, vecs[i].adr, vecs[i].wdat, r);
      if (!vecs[i].we) check($sformatf("vec%0d_rdat", i), r, vecs[i].exp);
      check($sformatf("vec%0d_csn", i), csn_s, vecs[i].exp_csn);
      @(posedge clk); #1;
      check($sformatf("vec%0d_ack_pulse", i), ack_s, 1'b0);
    end

    // stb without cyc is ignored
    wb_c.cyc = 1'b0; wb_c.stb = 1'b1; wb_c.we = 1'b1; wb_c.adr = WB_SPI_DATA; wb_c.dat = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("nocyc_ack", ack_s, 1'b0);
    end
    wb_c.stb = 1'b0; wb_c.we = 1'b0;
    check("nocyc_csn", csn_s, 1'b1);
    wb_acc(1'b0, WB_SPI_STATUS, 8'h00, r);
    check("nocyc_status", r, 8'h00);

    // Basic frame: 0xA5 out, 0x3C in
    do_reset(8'h3C);
    wb_acc(1'b1, WB_SPI_DATA, 8'hA5, r);
    measure(first, second, rises, done_at);
    check("t2_first_rise", first, 5);
    check("t2_rises", rises, 8);
    check("t2_done_at", done_at, 66);
    check("t2_sdo_byte", m_last, 8'hA5);
    wb_acc(1'b0, WB_SPI_STATUS, 8'h00, r);
    check("t2_status_rx", r, 8'h02);
    wb_acc(1'b0, WB_SPI_DATA, 8'h00, r);
    check("t2_data", r, 8'h3C);
    wb_acc(1'b0, WB_SPI_STATUS, 8'h00, r);
    check("t2_status_clr", r, 8'h00);

    // DATA read landing on the DONE edge: old byte returned, rx_valid kept
    wb_acc(1'b1, WB_SPI_DATA, 8'h77, r);
    repeat (64) @(posedge clk);
    #1;
    wb_acc(1'b0, WB_SPI_DATA, 8'h00, r);
    check("coll_old_byte", r, 8'h3C);
    wb_acc(1'b0, WB_SPI_STATUS, 8'h00, r);
    check("coll_status", r, 8'h02);
    wb_acc(1'b0, WB_SPI_DATA, 8'h00, r);
    check("coll_new_byte", r, 8'hA5);

    // Async reset in the middle of a frame
    wb_acc(1'b1, WB_SPI_DATA, 8'h99, r);
    repeat (20) @(posedge clk);
    #1;
    check("t1_csn_mid", csn_s, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("t1_csn", csn_s, 1'b1);
    check("t1_sck", sck_s, 1'b0);
    check("t1_sdo", sdo_s, 1'b0);
    check("t1_ack", ack_s, 1'b0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    wb_acc(1'b0, WB_SPI_STATUS, 8'h00, r);
    check("t1_status", r, 8'h00);
    wb_acc(1'b0, WB_SPI_DATA, 8'h00, r);
    check("t1_data", r, 8'h00);

    // Write while busy: dropped, overrun
    do_reset(8'h00);
    wb_acc(1'b1, WB_SPI_DATA, 8'h11, r);
    wb_acc(1'b1, WB_SPI_DATA, 8'h22, r);
    wb_acc(1'b0, WB_SPI_STATUS, 8'h00, r);
    check("t3_status_busy", r, 8'h05);
    wait_idle(s);
    check("t3_status_done", s, 8'h06);
    check("t3_sdo_byte", m_last, 8'h11);
    wb_acc(1'b1, WB_SPI_STATUS, 8'h04, r);
    wb_acc(1'b0, WB_SPI_STATUS, 8'h00, r);
    check("t3_status_clr", r, 8'h02);

    // Manual chip select across two frames, plus rx overwrite overrun
    do_reset(8'h81);
    wb_acc(1'b1, WB_SPI_CTRL, 8'h02, r);
    check("t4_csn_pre", csn_s, 1'b0);
    wb_acc(1'b1, WB_SPI_DATA, 8'hC3, r);
    wait_idle(s);
    check("t4_status1", s, 8'h02);
    check("t4_csn_between", csn_s, 1'b0);
    wb_acc(1'b1, WB_SPI_DATA, 8'h5E, r);
    wait_idle(s);
    check("t4_status2", s, 8'h06);
    check("t4_csn_after", csn_s, 1'b0);
    check("t4_sdo_byte", m_last, 8'h5E);
    wb_acc(1'b0, WB_SPI_DATA, 8'h00, r);
    check("t4_echo", r, 8'hC3);
    wb_acc(1'b1, WB_SPI_CTRL, 8'h03, r);
    check("t4_csn_level1", csn_s, 1'b1);

    // CLK_DIV = 1 instance
    sel = 1'b1;
    do_reset(8'h96);
    wb_acc(1'b1, WB_SPI_DATA, 8'hFF, r);
    measure(first, second, rises, done_at);
    check("t5_first_rise", first, 2);
    check("t5_sck_period", second - first, 2);
    check("t5_rises", rises, 8);
    check("t5_done_at", done_at, 18);
    check("t5_sdo_byte", m_last, 8'hFF);
    wb_acc(1'b0, WB_SPI_DATA, 8'h00, r);
    check("t5_data", r, 8'h96);
    sel = 1'b0;

    // Interrupt / CTRL.ie
    do_reset(8'h00);
`ifdef WB_SPI_CTRL_IRQ_EN
    wb_acc(1'b1, WB_SPI_CTRL, 8'h04, r);
    wb_acc(1'b1, WB_SPI_DATA, 8'h5A, r);
    repeat (65) @(posedge clk);
    #1;
    check("t6_irq_in_done", irq0, 1'b0);
    @(posedge clk); #1;
    check("t6_irq_rise", irq0, 1'b1);
    wb_acc(1'b0, WB_SPI_DATA, 8'h00, r);
    check("t6_irq_fall", irq0, 1'b0);
`else
    wb_acc(1'b1, WB_SPI_CTRL, 8'h04, r);
    wb_acc(1'b0, WB_SPI_CTRL, 8'h00, r);
    check("t6_ie_masked", r, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
